// File: rtl/audioqsys_simplified_audio_status_in.sv
`default_nettype none
// ============================================================================
// Module   : audioqsys_simplified_audio_status_in
// Purpose  : Avalon-MM readable status input port. Each asynchronous status
//            line (codec ready, jack detect, overflow flags) is passed through
//            a two-flop synchroniser, debounced, edge-detected into a sticky
//            edgecapture register and combined with irqmask into a level irq.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous active-low reset
//   address     in   2      register select (0 data, 1 irqmask, 2 rsvd, 3 edgecapture)
//   chipselect  in   1      slave select, qualifies writes only
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data, bits at and above WIDTH ignored
//   readdata    out  32     combinational read data, zero-extended
//   in_port     in   WIDTH  asynchronous status inputs
//   irq         out  1      level interrupt, |(edgecapture & irqmask)
// ============================================================================
module audioqsys_simplified_audio_status_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int EDGE_TYPE       = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   localparam int               c_cnt_w   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] w_db_value;
   logic [WIDTH-1:0] r_db_prev;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] r_edgecapture;
   logic [WIDTH-1:0] w_clear;
   logic             w_wr;

   // Two-flop synchroniser; nothing else looks at in_port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
   end

   // Per-bit debouncer. The counter measures how long the synced bit has
   // disagreed with the debounced value and restarts on any agreement, so a
   // pulse shorter than DEBOUNCE_CYCLES synced cycles is discarded.
   for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_db;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
         end else if (r_sync2[i] == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_max) begin
            r_db  <= r_sync2[i];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_db_value[i] = r_db;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_db_prev <= '0;
      end else begin
         r_db_prev <= w_db_value;
      end
   end

   if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_edge = w_db_value & ~r_db_prev;
   end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_edge = ~w_db_value & r_db_prev;
   end else begin : g_edge_any
      assign w_edge = w_db_value ^ r_db_prev;
   end

   assign w_wr    = chipselect & ~write_n;
   assign w_clear = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irqmask <= '0;
      end else if (w_wr && (address == 2'd1)) begin
         r_irqmask <= writedata[WIDTH-1:0];
      end
   end

   // A new edge is OR-ed in after the clear so it survives a same-cycle W1C.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edgecapture <= '0;
      end else begin
         r_edgecapture <= (r_edgecapture & ~w_clear) | w_edge;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata = 32'(w_db_value);
         2'd1:    readdata = 32'(r_irqmask);
         2'd3:    readdata = 32'(r_edgecapture);
         default: readdata = '0;
      endcase
   end

   assign irq = |(r_edgecapture & r_irqmask);

   if (WIDTH < 32) begin : g_unused_wdata
      logic w_unused_wdata;
      assign w_unused_wdata = &{1'b0, writedata[31:WIDTH]};
   end

endmodule
`default_nettype wire

// File: tb/tb_audioqsys_simplified_audio_status_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_audioqsys_simplified_audio_status_in
// Purpose  : Directed bench for the status input port. Two instances are
//            used: dut0 with rising-edge capture, dut1 with falling-edge
//            capture. Reads push their expected result into a queue and a
//            negedge monitor pops and compares readdata and irq.
// Revision : 1.0  initial release
// ============================================================================
module tb_audioqsys_simplified_audio_status_in;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n0;
   logic        reset_n1;
   logic [1:0]  address;
   logic        cs0;
   logic        cs1;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata0;
   logic [31:0] readdata1;
   logic [3:0]  in0;
   logic [3:0]  in1;
   logic        irq0;
   logic        irq1;
   logic        rd_req;

   int checks   = 0;
   int failures = 0;

   audioqsys_simplified_audio_status_in #(
      .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
   ) dut0 (
      .clk(clk), .reset_n(reset_n0), .address(address), .chipselect(cs0),
      .write_n(write_n), .writedata(writedata), .readdata(readdata0),
      .in_port(in0), .irq(irq0)
   );

   audioqsys_simplified_audio_status_in #(
      .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)
   ) dut1 (
      .clk(clk), .reset_n(reset_n1), .address(address), .chipselect(cs1),
      .write_n(write_n), .writedata(writedata), .readdata(readdata1),
      .in_port(in1), .irq(irq1)
   );

   typedef struct {
      int          tgt;
      logic [31:0] data;
      logic        irq;
      string       name;
   } exp_t;

   exp_t q[$];

   // Monitor: a read is presented for one cycle; compare at the falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act_d;
      logic        act_i;
      if (rd_req) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_read: no expected entry queued");
         end else begin
            e     = q.pop_front();
            act_d = (e.tgt == 0) ? readdata0 : readdata1;
            act_i = (e.tgt == 0) ? irq0 : irq1;
            if (act_d !== e.data || act_i !== e.irq) begin
               failures++;
               $display("FAIL %s: readdata=%h irq=%b expected readdata=%h irq=%b",
                        e.name, act_d, act_i, e.data, e.irq);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input int tgt, input logic [1:0] a, input logic [31:0] d,
                     input logic i, input string nm);
      exp_t e;
      e.tgt  = tgt;
      e.data = d;
      e.irq  = i;
      e.name = nm;
      address = a;
      q.push_back(e);
      rd_req = 1'b1;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic wr(input int tgt, input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write_n   = 1'b0;
      if (tgt == 0) cs0 = 1'b1;
      else          cs1 = 1'b1;
      @(posedge clk);
      #1;
      cs0     = 1'b0;
      cs1     = 1'b0;
      write_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      reset_n0  = 1'b0;
      reset_n1  = 1'b0;
      address   = 2'd0;
      cs0       = 1'b0;
      cs1       = 1'b0;
      write_n   = 1'b1;
      writedata = '0;
      in0       = 4'b0000;
      in1       = 4'b1000;   // held high through reset for the power-up case
      rd_req    = 1'b0;
      @(posedge clk);
      #1;
      tick(3);
      reset_n0 = 1'b1;
      reset_n1 = 1'b1;

      // Reset state
      rd(0, 2'd0, 32'h0, 1'b0, "rst_data");
      rd(0, 2'd1, 32'h0, 1'b0, "rst_mask");
      rd(0, 2'd2, 32'h0, 1'b0, "rst_rsvd");
      rd(0, 2'd3, 32'h0, 1'b0, "rst_edgecap");

      // Clean step 0000 -> 0101; next edge is edge 0
      in0 = 4'b0101;
      tick(3);                                    // after edge 2
      rd(0, 2'd0, 32'h0, 1'b0, "step_data_early");
      tick(3);                                    // after edge 6
      rd(0, 2'd0, 32'h5, 1'b0, "step_data");
      rd(0, 2'd3, 32'h5, 1'b0, "step_edgecap");   // after edge 7

      // Mask, W1C, read-only and reserved behaviour
      wr(0, 2'd1, 32'h1);
      rd(0, 2'd1, 32'h1, 1'b1, "mask_irq_on");
      wr(0, 2'd3, 32'h1);
      rd(0, 2'd3, 32'h4, 1'b0, "w1c_bit0");
      wr(0, 2'd0, 32'hF);
      rd(0, 2'd0, 32'h5, 1'b0, "data_readonly");
      wr(0, 2'd2, 32'hFFFF_FFFF);
      rd(0, 2'd2, 32'h0, 1'b0, "reserved_zero");
      wr(0, 2'd1, 32'hFFFF_FFF1);
      rd(0, 2'd1, 32'h1, 1'b0, "mask_high_bits");

      // Bit 1 glitch of 3 synced cycles is rejected
      in0 = 4'b0111;
      tick(3);
      in0 = 4'b0101;
      tick(10);
      rd(0, 2'd0, 32'h5, 1'b0, "glitch3_data");
      rd(0, 2'd3, 32'h4, 1'b0, "glitch3_edgecap");

      // Bit 1 pulse of 4 synced cycles passes through
      in0 = 4'b0111;
      tick(4);
      in0 = 4'b0101;
      tick(3);                                    // after edge 6
      rd(0, 2'd0, 32'h7, 1'b0, "pulse4_data");
      tick(10);
      rd(0, 2'd3, 32'h6, 1'b0, "pulse4_edgecap");
      rd(0, 2'd0, 32'h5, 1'b0, "pulse4_settled");
      wr(0, 2'd3, 32'h2);
      rd(0, 2'd3, 32'h4, 1'b0, "w1c_bit1");

      // W1C coinciding with a new capture on bit 2: set wins
      in0 = 4'b0001;
      tick(10);
      wr(0, 2'd3, 32'h4);
      rd(0, 2'd3, 32'h0, 1'b0, "edgecap_cleared");
      in0     = 4'b0101;
      address = 2'd0;
      found   = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         #1;
         if (readdata0[2]) found = 1'b1;
      end
      if (found) begin
         // data just changed, so the next edge is the capture edge
         wr(0, 2'd3, 32'h4);
         rd(0, 2'd3, 32'h4, 1'b0, "set_wins");
         wr(0, 2'd3, 32'h4);
         rd(0, 2'd3, 32'h0, 1'b0, "w1c_after_set");
      end else begin
         rd(0, 2'd0, 32'h5, 1'b0, "bit2_rise_timeout");
      end

      // dut1, falling-edge capture: power-up rise is not captured
      rd(1, 2'd0, 32'h8, 1'b0, "pwr_data");
      rd(1, 2'd3, 32'h0, 1'b0, "pwr_no_capture");
      in1 = 4'b0000;
      tick(10);
      rd(1, 2'd3, 32'h8, 1'b0, "fall_capture");
      rd(1, 2'd0, 32'h0, 1'b0, "fall_data");
      wr(1, 2'd1, 32'h8);
      rd(1, 2'd1, 32'h8, 1'b1, "fall_irq");

      // Reset in the middle of a falling debounce
      in1 = 4'b1000;
      tick(10);
      rd(1, 2'd3, 32'h8, 1'b1, "rise_no_capture");
      in1 = 4'b0000;
      tick(4);
      reset_n1 = 1'b0;
      rd(1, 2'd3, 32'h0, 1'b0, "midrst_edgecap");
      rd(1, 2'd1, 32'h0, 1'b0, "midrst_mask");
      rd(1, 2'd0, 32'h0, 1'b0, "midrst_data");
      tick(2);
      reset_n1 = 1'b1;
      tick(12);
      rd(1, 2'd3, 32'h0, 1'b0, "postrst_no_edge");
      rd(1, 2'd0, 32'h0, 1'b0, "postrst_data");

      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
